// File: rtl/iter_shifter_8bit.sv
`default_nettype none
// ============================================================================
//  Module   : iter_shifter_8bit
//  Purpose  : Multi-cycle 8-bit shifter, one bit position per clock. Same
//             operand/control semantics as the combinational barrel shifter
//             (din, shamt, lr, al); start launches, done pulses on completion.
//  Ports    : clk   - clock, rising edge
//             rst   - synchronous active-high reset
//             start - request, sampled only while idle
//             din   - 8-bit operand, captured on accepted start
//             shamt - shift amount 0..7, captured on accepted start
//             lr    - 1 = left, 0 = right, captured on accepted start
//             al    - right-shift fill: 1 = arithmetic, 0 = logical
//             rot   - rotate select (only with ITER_SHIFTER_ROTATE_EN)
//             busy  - operation in progress (state != IDLE)
//             done  - one-cycle completion pulse (state == FIN)
//             dout  - working shift register / last result
//  Config   : define ITER_SHIFTER_ROTATE_EN to add the rot port and the
//             rotate datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module iter_shifter_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic [2:0] shamt,
  input  logic       lr,
  input  logic       al,
`ifdef ITER_SHIFTER_ROTATE_EN
  input  logic       rot,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_sreg;
  logic [2:0] r_cnt;
  logic       r_lr;
  logic       r_al;
`ifdef ITER_SHIFTER_ROTATE_EN
  logic       r_rot;
`endif
  logic [7:0] w_shifted;

  // One-position step of the working register under the latched mode.
  // For arithmetic right shifts the fill is the current sreg[7]; that bit
  // never changes during the operation, so the result is din >>> shamt.
  always_comb begin
    if (r_lr) begin
      w_shifted = {r_sreg[6:0], 1'b0};
    end else begin
      w_shifted = {r_al & r_sreg[7], r_sreg[7:1]};
    end
`ifdef ITER_SHIFTER_ROTATE_EN
    if (r_rot) begin
      w_shifted = r_lr ? {r_sreg[6:0], r_sreg[7]} : {r_sreg[0], r_sreg[7:1]};
    end
`endif
  end

  // Next-state logic. shamt = 0 still visits SHIFT once before FIN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (r_cnt == 3'd0) w_next_state = ST_FIN;
      ST_FIN:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: load on accepted start, step while the count is non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= 8'h00;
      r_cnt  <= 3'd0;
      r_lr   <= 1'b0;
      r_al   <= 1'b0;
`ifdef ITER_SHIFTER_ROTATE_EN
      r_rot  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sreg <= din;
            r_cnt  <= shamt;
            r_lr   <= lr;
            r_al   <= al;
`ifdef ITER_SHIFTER_ROTATE_EN
            r_rot  <= rot;
`endif
          end
        end
        ST_SHIFT: begin
          if (r_cnt != 3'd0) begin
            r_sreg <= w_shifted;
            r_cnt  <= r_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_FIN);
  assign dout = r_sreg;

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter_8bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_shifter_8bit
//  Purpose  : Self-checking bench for iter_shifter_8bit. Expected results are
//             queued when an operation is launched and popped on done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iter_shifter_8bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       lr;
  logic       al;
  logic       rot_v;
  logic       busy;
  logic       done;
  logic [7:0] dout;

  int n_pass;
  int n_total;

  logic [7:0] exp_q[$];

  iter_shifter_8bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .shamt (shamt),
    .lr    (lr),
    .al    (al),
`ifdef ITER_SHIFTER_ROTATE_EN
    .rot   (rot_v),
`endif
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input int s,
                                       input logic l, input logic a, input logic r);
    logic [7:0] v;
    v = d;
    for (int i = 0; i < s; i++) begin
      if (r)      v = l ? {v[6:0], v[7]} : {v[0], v[7:1]};
      else if (l) v = {v[6:0], 1'b0};
      else        v = {a & v[7], v[7:1]};
    end
    return v;
  endfunction

  // Launch one operation; optionally hammer start/inputs while busy.
  task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] s,
                        input logic l, input logic a, input logic r, input bit perturb);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    din = d; shamt = s; lr = l; al = a; rot_v = r; start = 1'b1;
    exp_q.push_back(model(d, int'(s), l, a, r));
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    cycles = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 20) begin
      if (perturb) begin
        start = 1'b1;
        din = 8'($urandom);
        shamt = 3'($urandom);
        lr = ~lr;
        al = ~al;
      end
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, cycles, int'(s) + 2);
    check({tag, "_busy_cycles"}, busy_cnt, int'(s) + 2);
    if (exp_q.size() != 0) check({tag, "_dout"}, dout, exp_q.pop_front());
    else check({tag, "_queue"}, 0, 1);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_dout_hold"}, dout, model(d, int'(s), l, a, r));
  endtask

  initial begin
    int quiet;
    n_pass = 0; n_total = 0;
    rst = 1'b1; start = 1'b0; din = 8'h00; shamt = 3'd0; lr = 1'b0; al = 1'b0; rot_v = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", dout, 8'h00);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Reset wins over a simultaneous start.
    din = 8'h3C; start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", busy, 0);
    check("rst_start_dout", dout, 8'h00);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    run_op("left3", 8'b1011_0011, 3'd3, 1'b1, 1'b0, 1'b0, 0);
    check("left3_const", dout, 8'b1001_1000);
    run_op("rar2", 8'b1000_0110, 3'd2, 1'b0, 1'b1, 1'b0, 0);
    check("rar2_const", dout, 8'b1110_0001);
    run_op("rlr2", 8'b1000_0110, 3'd2, 1'b0, 1'b0, 1'b0, 0);
    check("rlr2_const", dout, 8'b0010_0001);
    run_op("zero", 8'hA5, 3'd0, 1'b1, 1'b0, 1'b0, 0);
    check("zero_const", dout, 8'hA5);
    run_op("max7", 8'hFF, 3'd7, 1'b1, 1'b0, 1'b0, 0);
    check("max7_const", dout, 8'h80);
    run_op("busyin", 8'h0F, 3'd4, 1'b1, 1'b0, 1'b0, 1);
    check("busyin_const", dout, 8'hF0);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) quiet++;
    end
    check("busyin_no_second_op", quiet, 0);
    run_op("rar7", 8'h80, 3'd7, 1'b0, 1'b1, 1'b0, 0);
    run_op("rlr5", 8'hC3, 3'd5, 1'b0, 1'b0, 1'b0, 0);

    // Reset two cycles into a shamt=6 operation.
    @(negedge clk);
    din = 8'h5A; shamt = 3'd6; lr = 1'b1; al = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dout", dout, 8'h00);
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) quiet++;
    end
    check("midrst_no_done", quiet, 0);
    run_op("after_rst", 8'h96, 3'd2, 1'b1, 1'b0, 1'b0, 0);

`ifdef ITER_SHIFTER_ROTATE_EN
    run_op("rotl1", 8'b1000_0001, 3'd1, 1'b1, 1'b0, 1'b1, 0);
    check("rotl1_const", dout, 8'b0000_0011);
    run_op("rotr3", 8'b0000_0111, 3'd3, 1'b0, 1'b1, 1'b1, 0);
    check("rotr3_const", dout, 8'b1110_0000);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
